led_strip_scheduler: RTL and testbench

- Sequences one ambient-lamp frame from the border-pixel ordering stage out to a WS2812-style LED strip.
- Once the ordering stage reports a complete frame, it fetches LED_NUM colours one at a time with an edge-triggered read request.
- Each 24-bit GRB word is serialised MSB-first onto a single-wire NRZ line, followed by a latch (reset) gap.
- Sits between the pixel ordering stage and the strip pad; all on one clock.

---
 rtl/led_pkg.sv | 36 +++
 rtl/ws2812_bit_tx.sv | 72 +++++++
 rtl/led_strip_scheduler.sv | 152 +++++++++++++++
 tb/tb_led_strip_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg
// Shared definitions for the LED strip scheduler: the scheduler state
// encoding, default WS2812 timing for a 50 MHz video clock, and the
// border-pixel count of the ambient-lamp frame.
// No ports (package).
package led_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        SHIFT,
        LATCH
    } state_t;

    // Capture grid; only the outer ring of pixels drives the strip.
    localparam int ROW_NUM = 96;
    localparam int COL_NUM = 128;

    // Corners are shared by a row and a column, hence the -4.
    localparam int LED_NUM_DEF = 2 * COL_NUM + 2 * ROW_NUM - 4;

    // 50 MHz timing: 1.25 us bit, 0.4 us / 0.8 us high, 300 us latch.
    localparam int BIT_CYC_DEF       = 63;
    localparam int T0H_CYC_DEF       = 20;
    localparam int T1H_CYC_DEF       = 40;
    localparam int RESET_CYC_DEF     = 15000;
    localparam int FETCH_TIMEOUT_DEF = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// ws2812_bit_tx
// Serialises one 24-bit GRB word MSB-first as WS2812 NRZ pulses.
// Ports:
//   clk        - clock
//   rst_n      - synchronous active-low reset
//   load       - one-cycle request to start sending data
//   data       - 24-bit word, sampled when load is high
//   dout       - registered serial line
//   word_done  - one-cycle pulse after the last bit's low tail
module ws2812_bit_tx #(
    parameter int BIT_CYC = 63,
    parameter int T0H_CYC = 20,
    parameter int T1H_CYC = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [23:0] data,
    output logic        dout,
    output logic        word_done
);

    localparam logic [CNT_W-1:0] BIT_END = CNT_W'(BIT_CYC);
    localparam logic [CNT_W-1:0] T0_HIGH = CNT_W'(T0H_CYC);
    localparam logic [CNT_W-1:0] T1_HIGH = CNT_W'(T1H_CYC);

    logic [23:0]      sh;
    logic [4:0]       bit_cnt;
    logic [CNT_W-1:0] cyc;
    logic             active;

    // cyc holds the in-bit position of the level being registered next.
    // Every bit starts high, so position 0 is driven high directly on
    // load and at each bit boundary, giving exactly BIT_CYC clocks/bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh        <= '0;
            bit_cnt   <= '0;
            cyc       <= '0;
            active    <= 1'b0;
            dout      <= 1'b0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (load) begin
                sh      <= data;
                bit_cnt <= '0;
                cyc     <= {{(CNT_W-1){1'b0}}, 1'b1};
                active  <= 1'b1;
                dout    <= 1'b1;
            end else if (active) begin
                if (cyc == BIT_END) begin
                    cyc <= {{(CNT_W-1){1'b0}}, 1'b1};
                    if (bit_cnt == 5'd23) begin
                        active    <= 1'b0;
                        dout      <= 1'b0;
                        word_done <= 1'b1;
                    end else begin
                        sh      <= {sh[22:0], 1'b0};
                        bit_cnt <= bit_cnt + 5'd1;
                        dout    <= 1'b1;
                    end
                end else begin
                    dout <= (cyc < (sh[23] ? T1_HIGH : T0_HIGH));
                    cyc  <= cyc + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/led_strip_scheduler.sv
// led_strip_scheduler
// Fetches one frame of GRB colours from the ordering stage and streams
// it to a WS2812 strip, followed by the latch gap.
// Ports:
//   video_clk   - single clock
//   rst_n       - synchronous active-low reset
//   en          - enable, only looked at while idle
//   wr_done     - a complete frame is readable
//   rgb_i       - GRB colour from the ordering stage
//   rgb_i_val   - one-cycle strobe marking rgb_i fresh
//   rd_req      - one-cycle fetch request (clean rising edge per pixel)
//   led_dout    - serial NRZ line to the strip
//   busy        - high whenever not idle
//   frame_done  - one-cycle pulse on return to idle
//   timeout_err - sticky fetch-timeout flag
module led_strip_scheduler
    import led_pkg::*;
#(
    parameter int LED_NUM       = LED_NUM_DEF,
    parameter int BIT_CYC       = BIT_CYC_DEF,
    parameter int T0H_CYC       = T0H_CYC_DEF,
    parameter int T1H_CYC       = T1H_CYC_DEF,
    parameter int RESET_CYC     = RESET_CYC_DEF,
    parameter int FETCH_TIMEOUT = FETCH_TIMEOUT_DEF
) (
    input  logic        video_clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        wr_done,
    input  logic [23:0] rgb_i,
    input  logic        rgb_i_val,
    output logic        rd_req,
    output logic        led_dout,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err
);

    localparam int CNT_W = $clog2(max3(BIT_CYC, RESET_CYC, FETCH_TIMEOUT) + 1);
    localparam int PIX_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;

    localparam logic [CNT_W-1:0] TMO_END   = CNT_W'(FETCH_TIMEOUT);
    localparam logic [CNT_W-1:0] LATCH_END = CNT_W'(RESET_CYC);
    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(LED_NUM - 1);

    if (!(T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC)) begin : g_timing_check
        $error("led_strip_scheduler: need T0H_CYC < T1H_CYC < BIT_CYC");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [PIX_W-1:0] pix_cnt;
    logic             trunc;
    logic             fetch_hit;
    logic             word_done;

    // Saturating so a stalled counter can never wrap back into range.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    // A strobe coinciding with expiry still counts as a real fetch.
    assign fetch_hit = (state == WAIT) && (rgb_i_val || (cnt >= TMO_END));

    ws2812_bit_tx #(
        .BIT_CYC (BIT_CYC),
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .CNT_W   (CNT_W)
    ) u_tx (
        .clk       (video_clk),
        .rst_n     (rst_n),
        .load      (fetch_hit),
        .data      (rgb_i),
        .dout      (led_dout),
        .word_done (word_done)
    );

    // Frame sequencer. cnt counts fetch-wait cycles (1 = first WAIT
    // cycle) and latch cycles (1 = first LATCH cycle). trunc remembers
    // that wr_done dropped so the current word still finishes before
    // the strip is latched.
    always_ff @(posedge video_clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pix_cnt     <= '0;
            trunc       <= 1'b0;
            rd_req      <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            rd_req     <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    pix_cnt <= '0;
                    trunc   <= 1'b0;
                    if (en && wr_done) begin
                        state  <= REQ;
                        rd_req <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                REQ: begin
                    state <= WAIT;
                    cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                    if (!wr_done) trunc <= 1'b1;
                end
                WAIT: begin
                    if (!wr_done) trunc <= 1'b1;
                    if (fetch_hit) begin
                        state <= SHIFT;
                        if (!rgb_i_val) timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                SHIFT: begin
                    if (word_done) begin
                        if (trunc || !wr_done || pix_cnt == LAST_PIX) begin
                            state <= LATCH;
                            cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            state   <= REQ;
                            rd_req  <= 1'b1;
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end else if (!wr_done) begin
                        trunc <= 1'b1;
                    end
                end
                LATCH: begin
                    if (cnt >= LATCH_END) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_strip_scheduler.sv
// tb_led_strip_scheduler
// Self-checking bench: plays the ordering stage (answers each rd_req
// rising edge after a chosen delay), decodes led_dout back into GRB
// words from pulse widths, and compares against what the frame should
// contain according to the strobe/timeout/truncation rules.
module tb_led_strip_scheduler;

    localparam int LED_NUM       = 4;
    localparam int BIT_CYC       = 10;
    localparam int T0H_CYC       = 3;
    localparam int T1H_CYC       = 7;
    localparam int RESET_CYC     = 20;
    localparam int FETCH_TIMEOUT = 8;

    logic        video_clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        wr_done;
    logic [23:0] rgb_i;
    logic        rgb_i_val;
    logic        rd_req;
    logic        led_dout;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;

    always #5 video_clk = ~video_clk;

    led_strip_scheduler #(
        .LED_NUM       (LED_NUM),
        .BIT_CYC       (BIT_CYC),
        .T0H_CYC       (T0H_CYC),
        .T1H_CYC       (T1H_CYC),
        .RESET_CYC     (RESET_CYC),
        .FETCH_TIMEOUT (FETCH_TIMEOUT)
    ) dut (
        .video_clk   (video_clk),
        .rst_n       (rst_n),
        .en          (en),
        .wr_done     (wr_done),
        .rgb_i       (rgb_i),
        .rgb_i_val   (rgb_i_val),
        .rd_req      (rd_req),
        .led_dout    (led_dout),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    int          compares = 0;
    int          fails    = 0;
    logic [23:0] colour [LED_NUM];
    int          dly    [LED_NUM];
    bit          extra  [LED_NUM];
    bit          exp_tmo;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        compares++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge video_clk);
        #1;
    endtask

    task automatic resetDut(input int n);
        rst_n     = 1'b0;
        en        = 1'b0;
        wr_done   = 1'b0;
        rgb_i_val = 1'b0;
        repeat (n) tick();
        rst_n   = 1'b1;
        exp_tmo = 1'b0;
    endtask

    task automatic randomFrame(input int dmin, input int dmax);
        for (int i = 0; i < LED_NUM; i++) begin
            colour[i] = 24'($urandom);
            dly[i]    = $urandom_range(dmax, dmin);
            extra[i]  = 1'b0;
        end
    endtask

    // Runs one frame cycle by cycle. Outputs are sampled 1 ns after the
    // edge, then inputs for the current cycle are driven. A strobe with
    // delay d lands in cycle req+d; dly=0 means the strobe never comes.
    task automatic applyStimulus(input int en_delay, input bit drop_en,
                                 input int trunc_at, input int abort_at);
        int          cyc, nreq, bitcnt, nwords, hi, last_rise, last_fall;
        int          frames, post, bad_period, bad_high, low_before, n_exp, p;
        int          req_cyc    [LED_NUM];
        int          first_rise [LED_NUM];
        logic [23:0] words      [LED_NUM];
        logic [23:0] acc;
        bit          prev_d, prev_rd, busy_at_req;
        cyc = 0; nreq = 0; bitcnt = 0; nwords = 0; hi = 0; last_rise = 0;
        last_fall = 0; frames = 0; post = 0; bad_period = 0; bad_high = 0;
        low_before = 0; acc = '0; busy_at_req = 1'b0;
        for (int i = 0; i < LED_NUM; i++) begin
            req_cyc[i] = -1; first_rise[i] = -1; words[i] = '0;
        end
        prev_d    = led_dout;
        prev_rd   = rd_req;
        wr_done   = 1'b1;
        en        = (en_delay == 0);
        rgb_i_val = 1'b0;
        while (cyc < 2500 && post < 8) begin
            tick();
            cyc++;
            if (abort_at > 0 && cyc == abort_at) return;
            if (rd_req && !prev_rd) begin
                if (nreq < LED_NUM) begin
                    req_cyc[nreq] = cyc;
                    rgb_i         = colour[nreq];
                end
                if (nreq == 0) busy_at_req = busy;
                nreq++;
            end
            prev_rd = rd_req;
            if (led_dout && !prev_d) begin
                if (bitcnt % 24 == 0) begin
                    if (bitcnt / 24 < LED_NUM) first_rise[bitcnt / 24] = cyc;
                end else if (cyc - last_rise != BIT_CYC) begin
                    bad_period++;
                end
                last_rise = cyc;
                hi        = 1;
            end else if (led_dout) begin
                hi++;
            end else if (prev_d) begin
                if (hi == T1H_CYC) acc = {acc[22:0], 1'b1};
                else if (hi == T0H_CYC) acc = {acc[22:0], 1'b0};
                else begin
                    bad_high++;
                    acc = {acc[22:0], 1'b0};
                end
                bitcnt++;
                last_fall = cyc;
                if (bitcnt % 24 == 0) begin
                    if (nwords < LED_NUM) words[nwords] = acc;
                    nwords++;
                end
            end
            prev_d = led_dout;
            if (frame_done) begin
                frames++;
                low_before = cyc - last_fall;
                en         = 1'b0;
                wr_done    = 1'b0;
            end
            if (frames > 0) post++;
            rgb_i_val = 1'b0;
            if (nreq > 0 && nreq <= LED_NUM) begin
                p = nreq - 1;
                if (dly[p] > 0 && cyc == req_cyc[p] + dly[p]) rgb_i_val = 1'b1;
                if (extra[p] && cyc == req_cyc[p] + 40) begin
                    rgb_i_val = 1'b1;
                    rgb_i     = 24'($urandom);
                end
                if (p == trunc_at && cyc == req_cyc[p] + 40) wr_done = 1'b0;
            end
            if (en_delay > 0 && cyc == en_delay && frames == 0) en = 1'b1;
            if (drop_en && nreq == 2) en = 1'b0;
        end
        rgb_i_val = 1'b0;
        n_exp = (trunc_at >= 0) ? trunc_at + 1 : LED_NUM;
        for (int i = 0; i < n_exp; i++)
            if (dly[i] == 0 || dly[i] > FETCH_TIMEOUT) exp_tmo = 1'b1;
        checkOutput("frame_done_count", frames, 1);
        checkOutput("rd_req_edges", nreq, n_exp);
        checkOutput("first_req_cycle", req_cyc[0], en_delay + 1);
        checkOutput("busy_in_frame", 32'(busy_at_req), 1);
        checkOutput("words_sent", nwords, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            checkOutput($sformatf("word%0d", i), 32'(words[i]), 32'(colour[i]));
            checkOutput($sformatf("fetch_to_dout%0d", i),
                        first_rise[i] - req_cyc[i],
                        (dly[i] >= 1 && dly[i] <= FETCH_TIMEOUT) ? dly[i] + 1
                                                                : FETCH_TIMEOUT + 1);
        end
        checkOutput("bit_period_errors", bad_period, 0);
        checkOutput("bit_high_errors", bad_high, 0);
        checkOutput("latch_low_long_enough", 32'(low_before >= RESET_CYC), 1);
        checkOutput("timeout_err", 32'(timeout_err), 32'(exp_tmo));
        checkOutput("busy_after_frame", 32'(busy), 0);
    endtask

    initial begin
        int act;
        rgb_i = '0;
        resetDut(3);
        checkOutput("reset_outputs",
                    32'({rd_req, led_dout, busy, frame_done, timeout_err}), 0);

        $display("[TB] nominal frame");
        colour[0] = 24'hFF0000; colour[1] = 24'h00FF00;
        colour[2] = 24'h0000FF; colour[3] = 24'hA5A5A5;
        for (int i = 0; i < LED_NUM; i++) begin
            dly[i] = 3; extra[i] = 1'b0;
        end
        applyStimulus(0, 1'b0, -1, 0);

        $display("[TB] enable gating");
        randomFrame(1, 7);
        applyStimulus(12, 1'b1, -1, 0);

        $display("[TB] strobe at timeout expiry, stray strobe in shift");
        randomFrame(1, 7);
        dly[1]   = FETCH_TIMEOUT;
        extra[2] = 1'b1;
        applyStimulus(0, 1'b0, -1, 0);

        $display("[TB] truncated frame");
        randomFrame(1, 7);
        applyStimulus(0, 1'b0, 1, 0);

        $display("[TB] missing strobe on last pixel");
        randomFrame(1, 7);
        colour[3] = 24'h123456;
        dly[3]    = 0;
        applyStimulus(0, 1'b0, -1, 0);

        $display("[TB] reset mid-shift");
        randomFrame(1, 7);
        applyStimulus(0, 1'b0, -1, 100);
        resetDut(3);
        checkOutput("reset_mid_frame",
                    32'({rd_req, led_dout, busy, frame_done, timeout_err}), 0);
        wr_done = 1'b1;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd_req || busy || led_dout) act++;
        end
        checkOutput("idle_after_reset", act, 0);
        wr_done = 1'b0;

        $display("[TB] random frames");
        for (int f = 0; f < 4; f++) begin
            randomFrame(0, 10);
            for (int i = 0; i < LED_NUM; i++) extra[i] = 1'($urandom_range(1, 0));
            applyStimulus(0, 1'b0,
                          ($urandom_range(2, 0) == 0) ? int'($urandom_range(3, 0)) : -1,
                          0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
